// File: rtl/freq_meter_ctrl.sv
// Frequency meter sequencer: clears a cascaded BCD counter chain and opens a
// gate of GATE_CYCLES clocks. During the gate it forwards one count enable per
// rising edge of sig_in, then latches the chain value and its overflow status
// into the display registers. Runs one-shot (single) or back-to-back (run).
module freq_meter_ctrl #(
  parameter int DIGITS      = 4,
  parameter int GATE_CYCLES = 50000000
) (
  input  logic                  gclk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  single,
  input  logic                  sig_in,
  input  logic [4*DIGITS-1:0]   cnt_bcd,
  output logic                  cnt_clr,
  output logic                  cnt_inc,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  disp_valid,
  output logic                  overflow,
  output logic                  busy
);

  // The counter reaches GATE_CYCLES on the last gate cycle, so it needs room
  // for that value and never wraps.
  localparam int             GW        = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    LATCH
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] gate_cnt;
  logic          sig_d;
  logic          rise;
  logic          ov_acc;

  assign rise = sig_in & ~sig_d;
  assign busy = (state != IDLE);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of block ordering.
  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the measurement sequence.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run || single) state_next = CLEAR;
      CLEAR:   state_next = GATE;
      GATE:    if (gate_cnt == GATE_LAST) state_next = SETTLE;
      SETTLE:  state_next = LATCH;
      LATCH:   state_next = run ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Edge-detect history, chain pulses, gate timing, overflow and display regs.
  // cnt_clr is registered from the next state so it is high exactly during
  // CLEAR. cnt_inc lags its rise by one cycle, which is why SETTLE exists:
  // a rise in the last gate cycle still reaches the chain before LATCH.
  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      gate_cnt   <= '0;
      sig_d      <= 1'b0;
      ov_acc     <= 1'b0;
      cnt_clr    <= 1'b0;
      cnt_inc    <= 1'b0;
      disp_bcd   <= '0;
      disp_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sig_d   <= sig_in;
      cnt_clr <= (state_next == CLEAR);
      cnt_inc <= (state == GATE) && rise;
      case (state)
        CLEAR: begin
          ov_acc   <= 1'b0;
          gate_cnt <= '0;
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          // A rise while the chain shows all 9s will wrap it to zero.
          if (rise && (cnt_bcd == ALL_NINES)) ov_acc <= 1'b1;
        end
        LATCH: begin
          disp_bcd   <= cnt_bcd;
          overflow   <= ov_acc;
          disp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/freq_meter_ctrl.md
Name: freq_meter_ctrl

Overview:
Measurement sequencer for a cascaded BCD digit counter chain. It forms a frequency meter: clear the chain, open a gate of GATE_CYCLES gclk cycles, and forward one count-enable pulse per rising edge of the measured signal. It then latches the chain's BCD value and overflow status into display registers. It runs in one-shot or continuous mode and sits between the input-signal conditioning and the 7-segment display driver.

Parameters:
DIGITS, 4, number of BCD digits in the counter chain (>=1)
GATE_CYCLES, 50000000, gate length in gclk cycles (>=1; one second at 50 MHz)

Ports:
gclk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
run  input  1  level; 1 = continuous back-to-back measurements
single  input  1  one-cycle request for one measurement when idle
sig_in  input  1  measured signal, already synchronous to gclk
cnt_bcd  input  4*DIGITS  live chain value; digit 0 in [3:0]
cnt_clr  output  1  one-cycle synchronous clear to every chain digit
cnt_inc  output  1  one-cycle count enable to chain digit 0
disp_bcd  output  4*DIGITS  last latched result
disp_valid  output  1  high once any result has been latched
overflow  output  1  last latched result wrapped past all-9s
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; gate counter=0; sig_d=0; ov_acc=0; cnt_clr=0; cnt_inc=0; disp_bcd=0; disp_valid=0; overflow=0; busy=0.
- Edge detect: sig_d registers sig_in; rise = sig_in & ~sig_d. Evaluated every cycle. Used only in GATE.
- cnt_clr and cnt_inc are registered outputs. The chain treats each as a single-cycle enable and responds on the next gclk edge.
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: if run=1 or single=1 go to CLEAR. single is sampled only in IDLE; single in other states is dropped, not queued.
- CLEAR (1 cycle): cnt_clr=1, ov_acc<=0, gate counter<=0, then go to GATE.
- GATE (exactly GATE_CYCLES cycles): cnt_inc<=rise; gate counter increments; leave after the cycle where count==GATE_CYCLES-1.
- Gate counter width is clog2(GATE_CYCLES+1); it never wraps.
- Overflow tracking: if rise occurs in GATE while cnt_bcd is all digits 4'h9, set ov_acc (sticky until next CLEAR).
- SETTLE (1 cycle): no pulses; lets the last cnt_inc propagate into cnt_bcd.
- LATCH (1 cycle): disp_bcd<=cnt_bcd; overflow<=ov_acc; disp_valid<=1. Then go to CLEAR if run=1, else IDLE.
- Continuous period: GATE_CYCLES+3 cycles from one cnt_clr pulse to the next.
- Rises occurring outside GATE are ignored (no cnt_inc).
- run dropped mid-measurement: the current measurement completes and latches, then the FSM goes to IDLE.
- run and single both high in IDLE: same as run.
- disp_* hold their value between LATCH cycles; disp_valid stays high until reset.
- Reset mid-operation: immediate return to reset values with no partial latch. After reset release, the FSM waits in IDLE for a new request.

Test Plan:
(Bench uses GATE_CYCLES=20, DIGITS=2, and a behavioural 2-digit BCD chain driven by cnt_clr/cnt_inc.)
1. Reset pulse with sig_in toggling -> all outputs 0; busy=0; no cnt_clr or cnt_inc while IDLE.
2. single=1 for 1 cycle; sig_in rises every 4 cycles -> 5 cnt_inc pulses; disp_bcd=8'h05, overflow=0, disp_valid=1; busy falls 23 cycles after CLEAR.
3. run=1; sig_in rises every 2 cycles -> each latch gives disp_bcd=8'h10; cnt_clr pulses every 23 cycles; no cnt_inc outside GATE.
4. DIGITS=1 instance, run=1, rise every 2 cycles -> 10th rise occurs at chain value 9 -> disp_bcd=4'h0, overflow=1. Next measurement with rise every 4 cycles -> disp_bcd=4'h5, overflow=0.
5. run=1, then run=0 at gate cycle 10; single pulsed mid-GATE -> exactly one more LATCH, then IDLE; single ignored, no extra measurement.
6. reset=0 at gate cycle 8 with disp_bcd=8'h10 held -> disp_bcd=0, disp_valid=0, busy=0 immediately; after release, no LATCH occurs until run or single.
